// File: rtl/vrf_banked_if.sv
// Request/response bundle between issue logic and the banked vector register file.
interface vrf_banked_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_NUM    = 32,
    parameter int LANES      = 4,
    parameter int NUM_OPS    = 3
);
    localparam int ADDR_B = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam int ELEM_B = (LANES > 1) ? $clog2(LANES) : 1;

    logic                           rd_req;
    logic                           rd_ready;
    logic [NUM_OPS-1:0]             rd_op_en;
    logic [NUM_OPS*ADDR_B-1:0]      rd_addr;
    logic                           rd_valid;
    logic [ELEM_B-1:0]              rd_elem;
    logic [NUM_OPS*DATA_WIDTH-1:0]  op_rdata;
    logic                           wr_valid;
    logic                           wr_ready;
    logic [ADDR_B-1:0]              wr_addr;
    logic [ELEM_B-1:0]              wr_elem;
    logic [DATA_WIDTH/8-1:0]        wr_be;
    logic [DATA_WIDTH-1:0]          wdata;
    logic [LANES-1:0]               mask_rdata;

    modport master (
        output rd_req, rd_op_en, rd_addr, rd_elem,
        output wr_valid, wr_addr, wr_elem, wr_be, wdata,
        input  rd_ready, rd_valid, op_rdata, wr_ready, mask_rdata
    );

    modport slave (
        input  rd_req, rd_op_en, rd_addr, rd_elem,
        input  wr_valid, wr_addr, wr_elem, wr_be, wdata,
        output rd_ready, rd_valid, op_rdata, wr_ready, mask_rdata
    );
endinterface

// File: rtl/vrf_banked.sv
// Lane-banked vector register file: REG_NUM registers striped one element per
// lane, multi-operand sequential fetch with write-first forwarding, cleared
// to zero after reset, live v0 mask view.
module vrf_banked #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_NUM    = 32,
    parameter int LANES      = 4,
    parameter int NUM_OPS    = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    vrf_banked_if.slave  bus
);
    localparam int ADDR_B = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam int ELEM_B = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int OP_B   = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_B:0] REG_LIM  = (ADDR_B+1)'(REG_NUM);
    localparam logic [ELEM_B:0] LANE_LIM = (ELEM_B+1)'(LANES);

    typedef enum logic [1:0] {INIT, IDLE, READ, DONE} state_t;

    state_t                          state_q, state_d;
    logic [ADDR_B-1:0]               cnt_q, cnt_d;
    logic [NUM_OPS-1:0]              pend_q, pend_d;
    logic [NUM_OPS-1:0][ADDR_B-1:0]  pend_addr_q;
    logic [OP_B-1:0]                 sel;
    logic [NUM_OPS-1:0]              sel_oh;
    logic [ADDR_B-1:0]               rd_addr_cur;
    logic                            rd_acc, wr_acc;
    logic [LANES-1:0][NUM_OPS-1:0][DATA_WIDTH-1:0] op_all;
    logic [LANES-1:0]                mask;

    function automatic logic addr_ok(input logic [ADDR_B-1:0] a);
        return {1'b0, a} < REG_LIM;
    endfunction

    assign bus.rd_ready   = !rst_i && (state_q == IDLE);
    assign bus.wr_ready   = !rst_i && (state_q != INIT);
    assign bus.rd_valid   = !rst_i && (state_q == DONE);
    assign bus.mask_rdata = mask;

    assign rd_acc = bus.rd_req && bus.rd_ready;
    assign wr_acc = bus.wr_valid && bus.wr_ready;

    // lowest pending operand is fetched first
    always_comb begin
        sel    = '0;
        sel_oh = '0;
        for (int k = NUM_OPS-1; k >= 0; k--) begin
            if (pend_q[k]) begin
                sel    = OP_B'(k);
                sel_oh = NUM_OPS'(1) << k;
            end
        end
    end

    assign rd_addr_cur = pend_addr_q[sel];

    // FSM state, clear counter and pending mask registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= INIT;
            cnt_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // next-state: clear sweep, accept, per-operand fetch, completion pulse
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ADDR_B'(REG_NUM-1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                if (rd_acc) begin
                    pend_d  = bus.rd_op_en;
                    state_d = (|bus.rd_op_en) ? READ : DONE;
                end
            end
            READ: begin
                pend_d = pend_q & ~sel_oh;
                if (pend_d == '0) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = INIT;
        endcase
    end

    // operand addresses are held for the whole fetch sequence
    always_ff @(posedge clk_i) begin
        if (rst_i)       pend_addr_q <= '0;
        else if (rd_acc) pend_addr_q <= bus.rd_addr;
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [DATA_WIDTH-1:0]              mem [REG_NUM];
        logic [DATA_WIDTH-1:0]              raw, fwd;
        logic [NUM_OPS-1:0][DATA_WIDTH-1:0] op_reg;
        logic                               wr_hit;

        assign wr_hit = wr_acc && (bus.wr_elem == ELEM_B'(l)) && addr_ok(bus.wr_addr);

        // bank storage: zero sweep during INIT, byte-masked writes otherwise
        always_ff @(posedge clk_i) begin
            if (state_q == INIT) begin
                mem[cnt_q] <= '0;
            end else if (wr_hit) begin
                for (int b = 0; b < NBYTES; b++)
                    if (bus.wr_be[b]) mem[bus.wr_addr][b*8 +: 8] <= bus.wdata[b*8 +: 8];
            end
        end

        assign raw = addr_ok(rd_addr_cur) ? mem[rd_addr_cur] : '0;

        // write-first: a same-cycle write to the fetched register is merged in
        always_comb begin
            fwd = raw;
            if (wr_hit && (bus.wr_addr == rd_addr_cur)) begin
                for (int b = 0; b < NBYTES; b++)
                    if (bus.wr_be[b]) fwd[b*8 +: 8] = bus.wdata[b*8 +: 8];
            end
        end

        // operand snapshot for this lane; untouched operands keep their value
        always_ff @(posedge clk_i) begin
            if (rst_i)                op_reg      <= '0;
            else if (state_q == READ) op_reg[sel] <= fwd;
        end

        assign op_all[l] = op_reg;
        assign mask[l]   = mem[0][0];
    end

    // operand output lane mux; lanes beyond LANES read as zero
    always_comb begin
        bus.op_rdata = '0;
        if ({1'b0, bus.rd_elem} < LANE_LIM) begin
            for (int k = 0; k < NUM_OPS; k++)
                bus.op_rdata[k*DATA_WIDTH +: DATA_WIDTH] = op_all[bus.rd_elem][k];
        end
    end

endmodule
